alu_writeback: RTL and testbench
================================

# alu_writeback

Result/flags commit stage directly downstream of the ALU. Takes one ALU result per transaction (8/16/32-bit), merges it into the internal 8×32 general-register file or stores it byte-serially over the 8-bit memory bus, and commits the ALU flag word into the architectural FLAGS register. It also supplies two combinational register read ports to the operand-fetch stage that feeds the ALU.

## Interface
Parameters:
- FLAGS_RST, 12'h002, FLAGS reset value (bit 1 always reads 1).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  transaction request; accepted only on an edge where busy=0.
- isize  in  1  0 = byte operand, 1 = word/dword.
- opsize  in  1  with isize=1: 0 = 16-bit, 1 = 32-bit.
- alumode  in  3  ALU op code; 7 (CMP) = flags-only, no result write.
- dst_reg  in  1  1 = register destination, 0 = memory destination.
- regn  in  3  destination register index.
- ea  in  32  memory destination address (byte 0).
- result  in  32  ALU result, already size-masked.
- flags_in  in  12  ALU flag word to commit.
- rsel1, rsel2  in  3  read-port indices.
- rdat1, rdat2  out  32  raw 32-bit contents of rsel1/rsel2, combinational.
- mem_address  out  32  store address.
- mem_out  out  8  store byte.
- mem_we  out  1  store strobe.
- mem_ready  in  1  byte accepted on an edge where mem_we=1 and mem_ready=1.
- flags  out  12  architectural FLAGS register.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- All inputs except mem_ready, rsel1/2 are captured at the accept edge; later changes are ignored.
- States: IDLE, REG, MEM. busy = (state != IDLE), registered.
- IDLE, start=1: alumode=7 or dst_reg=1 → REG; otherwise → MEM with byte counter k=0, count n = 1/2/4 for byte/16/32.
- REG (one cycle), at its closing edge:
  - alumode=7: no register change.
  - Byte: regn[2]=0 → reg[regn][7:0] ← result[7:0]; regn[2]=1 → reg[regn[1:0]][15:8] ← result[7:0] (AH/CH/DH/BH). Other bits unchanged.
  - 16-bit: reg[regn][15:0] ← result[15:0], [31:16] unchanged. 32-bit: full write.
  - flags ← {flags_in[11:2], 1'b1, flags_in[0]}; → IDLE; done=1 next cycle.
- MEM: drive mem_we=1, mem_address=ea+k (32-bit wrap), mem_out=result[8k+7:8k] (little-endian). Edge with mem_ready=1: k←k+1; if k was n−1, commit flags as above, → IDLE, done=1 next cycle. mem_ready=0: hold all bus outputs stable.
- Read ports show register state as of the last edge; no bypass of a same-cycle write.
- start with busy=1 is ignored (not queued). start during the done cycle is accepted (busy=0).

## Timing
- Reset (any state, mid-store included): state=IDLE, all 8 registers=0, flags=FLAGS_RST, busy=0, done=0, mem_we=0, mem_address=0, mem_out=0; no pending flag commit survives.
- Register/CMP transaction, accept edge E0: busy=1 cycle E0..E1; write + flags visible after E1; done=1 cycle E1..E2.
- Memory transaction, mem_ready held 1: byte k on bus cycle E(k)..E(k+1); after n bytes, done pulse; latency to done = n+1 cycles; each mem_ready=0 cycle adds one.
- Throughput: one register transaction every 2 cycles (start held high).
- mem_we low whenever state != MEM.

## Test plan
- Reset then read all rsel → rdat=0, flags=12'h002, busy=0, mem_we=0.
- reg0=32'h11223344; byte write regn=4, result=8'hAB → reg0=32'h1122AB44; 16-bit write regn=0, result=16'h5566 → reg0=32'h11225566; done exactly one cycle each.
- CMP (alumode=7) dst_reg=1, regn=1, flags_in=12'h8C5 → reg1 unchanged, flags=12'h8C7, done after 2 cycles.
- 32-bit store ea=32'hFFFFFFFE, result=32'hDEADBEEF, mem_ready=1 → bytes EF,BE,AD,DE at FFFFFFFE, FFFFFFFF, 00000000, 00000001; done 5 cycles after accept.
- 16-bit store with mem_ready low 3 cycles on byte 0 → address/data stable throughout, done 6 cycles after accept; start pulses while busy ignored.
- Assert reset during byte 1 of a 4-byte store → next cycle mem_we=0, busy=0, flags=12'h002, no done pulse.

Source files
------------

// File: rtl/alu_writeback.sv
// Commit stage behind the ALU: merges results into the 8x32 register file or
// streams them byte-serially to memory, then commits the ALU flag word.
module alu_writeback #(
  parameter logic [11:0] FLAGS_RST = 12'h002
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        isize,
  input  logic        opsize,
  input  logic [2:0]  alumode,
  input  logic        dst_reg,
  input  logic [2:0]  regn,
  input  logic [31:0] ea,
  input  logic [31:0] result,
  input  logic [11:0] flags_in,
  input  logic [2:0]  rsel1,
  input  logic [2:0]  rsel2,
  output logic [31:0] rdat1,
  output logic [31:0] rdat2,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [11:0] flags,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, REG, MEM} state_t;

  typedef struct packed {
    logic        isize;
    logic        opsize;
    logic        cmp;
    logic [2:0]  regn;
    logic [31:0] ea;
    logic [31:0] result;
    logic [11:0] flags_in;
  } req_t;

  state_t           state;
  req_t             req;
  logic [7:0][31:0] regs;
  logic [1:0]       k;
  logic [1:0]       last;
  logic [1:0]       k_nxt;
  logic [11:0]      flags_commit;

  assign rdat1        = regs[rsel1];
  assign rdat2        = regs[rsel2];
  assign k_nxt        = k + 2'd1;
  assign flags_commit = {req.flags_in[11:2], 1'b1, req.flags_in[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      req         <= '0;
      regs        <= '0;
      k           <= '0;
      last        <= '0;
      flags       <= FLAGS_RST | 12'h002;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_out     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req  <= '{isize: isize, opsize: opsize, cmp: (alumode == 3'd7),
                    regn: regn, ea: ea, result: result, flags_in: flags_in};
          busy <= 1'b1;
          if (alumode == 3'd7 || dst_reg) begin
            state <= REG;
          end else begin
            state       <= MEM;
            k           <= '0;
            last        <= isize ? (opsize ? 2'd3 : 2'd1) : 2'd0;
            mem_we      <= 1'b1;
            mem_address <= ea;
            mem_out     <= result[7:0];
          end
        end
        REG: begin
          if (!req.cmp) begin
            // Byte writes with regn[2] set land in bits 15:8 of regs 0..3.
            if (!req.isize) begin
              if (req.regn[2]) regs[{1'b0, req.regn[1:0]}][15:8] <= req.result[7:0];
              else             regs[req.regn][7:0]               <= req.result[7:0];
            end else if (!req.opsize) begin
              regs[req.regn][15:0] <= req.result[15:0];
            end else begin
              regs[req.regn] <= req.result;
            end
          end
          flags <= flags_commit;
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        MEM: if (mem_ready) begin
          if (k == last) begin
            flags  <= flags_commit;
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            mem_we <= 1'b0;
          end else begin
            k           <= k_nxt;
            mem_address <= req.ea + {30'd0, k_nxt};
            mem_out     <= req.result[{k_nxt, 3'b000} +: 8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized self-checking bench for alu_writeback with an abstract register/flags model.
module tb_alu_writeback;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, isize = 1'b0, opsize = 1'b0;
  logic [2:0]  alumode = '0, regn = '0, rsel1 = '0, rsel2 = '0;
  logic        dst_reg = 1'b0, mem_ready = 1'b0;
  logic [31:0] ea = '0, result = '0;
  logic [11:0] flags_in = '0;
  logic [31:0] rdat1, rdat2, mem_address;
  logic [7:0]  mem_out;
  logic        mem_we, busy, done;
  logic [11:0] flags;

  int errs = 0, checks = 0;
  logic [31:0] mregs [8];
  logic [11:0] mflags;

  alu_writeback #(.FLAGS_RST(12'h002)) dut (
    .clock(clock), .reset(reset), .start(start), .isize(isize), .opsize(opsize),
    .alumode(alumode), .dst_reg(dst_reg), .regn(regn), .ea(ea), .result(result),
    .flags_in(flags_in), .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .mem_address(mem_address), .mem_out(mem_out), .mem_we(mem_we),
    .mem_ready(mem_ready), .flags(flags), .busy(busy), .done(done));

  always #5 clock = ~clock;

  // Reference: architectural effect of a register/CMP commit.
  function automatic void m_reg(input bit isz, input bit osz, input logic [2:0] am,
                                input logic [2:0] rn, input logic [31:0] res,
                                input logic [11:0] fi);
    logic [2:0] lo;
    lo = {1'b0, rn[1:0]};
    if (am != 3'd7) begin
      if (!isz) begin
        if (rn[2]) mregs[lo] = (mregs[lo] & 32'hFFFF00FF) | ((res & 32'hFF) << 8);
        else       mregs[rn] = (mregs[rn] & 32'hFFFFFF00) | (res & 32'hFF);
      end else if (!osz) mregs[rn] = (mregs[rn] & 32'hFFFF0000) | (res & 32'hFFFF);
      else mregs[rn] = res;
    end
    mflags = fi | 12'h002;
  endfunction

  // Drive a request through its accept edge, then scramble the inputs.
  task automatic issue(input bit isz, input bit osz, input logic [2:0] am, input bit dr,
                       input logic [2:0] rn, input logic [31:0] e, input logic [31:0] res,
                       input logic [11:0] fi);
    isize = isz; opsize = osz; alumode = am; dst_reg = dr; regn = rn;
    ea = e; result = res; flags_in = fi; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    result = $urandom; ea = $urandom; flags_in = 12'($urandom);
    regn = 3'($urandom); isize = 1'($urandom); opsize = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mflags = 12'h002;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (flags !== 12'h002) begin errs++; $display("FAIL reset_flags got=%h exp=002", flags); end
    checks++; if (mem_address !== 32'h0 || mem_out !== 8'h0) begin
      errs++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_address, mem_out); end
    reset = 1'b0;
    for (int i = 0; i < 8; i += 2) begin
      rsel1 = 3'(i); rsel2 = 3'(i + 1); #1;
      checks++; if (rdat1 !== 32'h0 || rdat2 !== 32'h0) begin
        errs++; $display("FAIL reset_rdat%0d got=%h/%h exp=0/0", i, rdat1, rdat2); end
    end
  endtask

  task automatic test_reg_writes();
    rsel1 = 3'd0;
    issue(1, 1, 3'd0, 1, 3'd0, 32'h0, 32'h11223344, 12'h001);
    m_reg(1, 1, 3'd0, 3'd0, 32'h11223344, 12'h001);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL reg32_accept busy/done=%b%b exp=10", busy, done); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL reg32_done busy/done=%b%b exp=01", busy, done); end
    checks++; if (rdat1 !== 32'h11223344) begin errs++; $display("FAIL reg32_val got=%h exp=11223344", rdat1); end
    issue(0, 0, 3'd0, 1, 3'd4, 32'h0, 32'h000000AB, 12'h0F0);
    m_reg(0, 0, 3'd0, 3'd4, 32'h000000AB, 12'h0F0);
    @(posedge clock); #1;
    checks++; if (done !== 1'b1) begin errs++; $display("FAIL regah_done got=%b exp=1", done); end
    checks++; if (rdat1 !== 32'h1122AB44 || rdat1 !== mregs[0]) begin
      errs++; $display("FAIL regah_val got=%h exp=1122AB44", rdat1); end
    checks++; if (flags !== mflags) begin errs++; $display("FAIL regah_flags got=%h exp=%h", flags, mflags); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL regah_pulse got=%b exp=0", done); end
    issue(1, 0, 3'd2, 1, 3'd0, 32'h0, 32'h00005566, 12'h3FC);
    m_reg(1, 0, 3'd2, 3'd0, 32'h00005566, 12'h3FC);
    @(posedge clock); #1;
    checks++; if (rdat1 !== 32'h11225566) begin errs++; $display("FAIL reg16_val got=%h exp=11225566", rdat1); end
    checks++; if (flags !== 12'h3FE) begin errs++; $display("FAIL reg16_flags got=%h exp=3FE", flags); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reg16_pulse got=%b exp=0", done); end
  endtask

  task automatic test_cmp();
    int lat;
    issue(1, 1, 3'd0, 1, 3'd1, 32'h0, 32'hCAFEF00D, 12'h000);
    m_reg(1, 1, 3'd0, 3'd1, 32'hCAFEF00D, 12'h000);
    @(posedge clock); #1;
    rsel1 = 3'd1;
    issue(1, 1, 3'd7, 1, 3'd1, 32'h0, 32'h12345678, 12'h8C5);
    m_reg(1, 1, 3'd7, 3'd1, 32'h12345678, 12'h8C5);
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin @(posedge clock); #1; lat++; end
    checks++; if (lat != 1) begin errs++; $display("FAIL cmp_latency got=%0d exp=1", lat); end
    checks++; if (rdat1 !== 32'hCAFEF00D) begin errs++; $display("FAIL cmp_reg got=%h exp=CAFEF00D", rdat1); end
    checks++; if (flags !== 12'h8C7) begin errs++; $display("FAIL cmp_flags got=%h exp=8C7", flags); end
  endtask

  task automatic test_store_wrap();
    logic [31:0] e, d;
    e = 32'hFFFFFFFE; d = 32'hDEADBEEF;
    mem_ready = 1'b1;
    issue(1, 1, 3'd1, 0, 3'd0, e, d, 12'h555);
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_we !== 1'b1 || mem_address !== e + 32'(k) || mem_out !== d[8*k +: 8] || done !== 1'b0) begin
        errs++; $display("FAIL wrap_byte%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                         k, mem_we, mem_address, mem_out, e + 32'(k), d[8*k +: 8]); end
      @(posedge clock); #1;
    end
    mflags = 12'h557;
    checks++; if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL wrap_done done/we/busy=%b%b%b exp=100", done, mem_we, busy); end
    checks++; if (flags !== mflags) begin errs++; $display("FAIL wrap_flags got=%h exp=%h", flags, mflags); end
  endtask

  task automatic test_store_stall();
    mem_ready = 1'b0;
    rsel2 = 3'd7;
    issue(1, 0, 3'd0, 0, 3'd0, 32'h00001000, 32'h0000BEEF, 12'h300);
    for (int s = 0; s < 3; s++) begin
      checks++; if (mem_we !== 1'b1 || mem_address !== 32'h1000 || mem_out !== 8'hEF || busy !== 1'b1) begin
        errs++; $display("FAIL stall_hold%0d got we=%b a=%h d=%h exp we=1 a=00001000 d=EF",
                         s, mem_we, mem_address, mem_out); end
      if (s == 1) begin
        isize = 1'b1; opsize = 1'b1; alumode = 3'd0; dst_reg = 1'b1; regn = 3'd7;
        result = 32'hFFFFFFFF; start = 1'b1;
      end
      @(posedge clock); #1;
      start = 1'b0;
    end
    mem_ready = 1'b1;
    checks++; if (mem_address !== 32'h1000 || mem_out !== 8'hEF) begin
      errs++; $display("FAIL stall_b0 got a=%h d=%h exp a=00001000 d=EF", mem_address, mem_out); end
    @(posedge clock); #1;
    checks++; if (mem_address !== 32'h1001 || mem_out !== 8'hBE || done !== 1'b0) begin
      errs++; $display("FAIL stall_b1 got a=%h d=%h exp a=00001001 d=BE", mem_address, mem_out); end
    @(posedge clock); #1;
    mflags = 12'h302;
    checks++; if (done !== 1'b1 || flags !== mflags) begin
      errs++; $display("FAIL stall_done got done=%b f=%h exp done=1 f=%h", done, flags, mflags); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || rdat2 !== mregs[7]) begin
      errs++; $display("FAIL stall_ignored got busy=%b done=%b r7=%h exp 0 0 %h", busy, done, rdat2, mregs[7]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [7];
    for (int i = 0; i < 7; i++) vals[i] = $urandom;
    rsel1 = 3'd3;
    isize = 1'b1; opsize = 1'b1; alumode = 3'd0; dst_reg = 1'b1; regn = 3'd3;
    flags_in = 12'h0A4; result = vals[0]; start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      result = vals[c + 1];
      checks++; if (done !== 1'(c % 2) || busy !== 1'(1 - c % 2)) begin
        errs++; $display("FAIL b2b_edge%0d got busy/done=%b%b exp=%0d%0d", c, busy, done, 1 - c % 2, c % 2); end
    end
    start = 1'b0;
    m_reg(1, 1, 3'd0, 3'd3, vals[4], 12'h0A4);
    checks++; if (rdat1 !== mregs[3] || flags !== mflags) begin
      errs++; $display("FAIL b2b_val got=%h/%h exp=%h/%h", rdat1, flags, mregs[3], mflags); end
  endtask

  task automatic test_reset_mid_store();
    mem_ready = 1'b1;
    issue(1, 1, 3'd0, 0, 3'd0, 32'h00002000, 32'h01020304, 12'hFF0);
    @(posedge clock); #1;
    checks++; if (mem_address !== 32'h2001 || mem_out !== 8'h03) begin
      errs++; $display("FAIL rst_b1 got a=%h d=%h exp a=00002001 d=03", mem_address, mem_out); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mflags = 12'h002;
    checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || flags !== mflags || mem_address !== 32'h0) begin
      errs++; $display("FAIL rst_mid got we=%b busy=%b done=%b f=%h a=%h exp 0 0 0 002 0",
                       mem_we, busy, done, flags, mem_address); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || flags !== mflags) begin
      errs++; $display("FAIL rst_after got done=%b busy=%b f=%h exp 0 0 002", done, busy, flags); end
    for (int i = 0; i < 8; i += 2) begin
      rsel1 = 3'(i); rsel2 = 3'(i + 1); #1;
      checks++; if (rdat1 !== 32'h0 || rdat2 !== 32'h0) begin
        errs++; $display("FAIL rst_rdat%0d got=%h/%h exp=0/0", i, rdat1, rdat2); end
    end
  endtask

  task automatic test_random();
    bit isz, osz, dr;
    logic [2:0] am, rn;
    logic [31:0] e, res;
    logic [11:0] fi;
    int kind, n, kb, lat;
    bit rdy;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 4);
      isz = 1'($urandom); osz = 1'($urandom); rn = 3'($urandom);
      e = $urandom; fi = 12'($urandom); res = $urandom;
      res = !isz ? (res & 32'hFF) : (!osz ? (res & 32'hFFFF) : res);
      am = 3'($urandom_range(0, 6)); dr = 1'b1;
      if (kind == 3) begin am = 3'd7; dr = 1'($urandom); end
      if (kind == 4) dr = 1'b0;
      rsel1 = 3'($urandom);
      if (am == 3'd7 || dr) begin
        issue(isz, osz, am, dr, rn, e, res, fi);
        m_reg(isz, osz, am, rn, res, fi);
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin @(posedge clock); #1; lat++; end
        checks++; if (lat != 1) begin errs++; $display("FAIL rnd%0d_reglat got=%0d exp=1", t, lat); end
      end else begin
        n = isz ? (osz ? 4 : 2) : 1;
        kb = 0;
        mem_ready = 1'($urandom);
        issue(isz, osz, am, dr, rn, e, res, fi);
        for (int it = 0; it < 100; it++) begin
          if (kb == n) break;
          checks++; if (mem_we !== 1'b1 || done !== 1'b0 || mem_address !== e + 32'(kb) || mem_out !== res[8*kb +: 8]) begin
            errs++; $display("FAIL rnd%0d_byte%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                             t, kb, mem_we, mem_address, mem_out, e + 32'(kb), res[8*kb +: 8]); end
          rdy = 1'($urandom);
          mem_ready = rdy;
          @(posedge clock); #1;
          if (rdy) kb++;
        end
        mflags = fi | 12'h002;
        checks++; if (kb != n || done !== 1'b1 || mem_we !== 1'b0) begin
          errs++; $display("FAIL rnd%0d_memdone got kb=%0d done=%b we=%b exp kb=%0d done=1 we=0",
                           t, kb, done, mem_we, n); end
      end
      checks++; if (rdat1 !== mregs[rsel1] || flags !== mflags) begin
        errs++; $display("FAIL rnd%0d_state got r%0d=%h f=%h exp %h %h", t, rsel1, rdat1, flags, mregs[rsel1], mflags); end
    end
    for (int i = 0; i < 8; i += 2) begin
      rsel1 = 3'(i); rsel2 = 3'(i + 1); #1;
      checks++; if (rdat1 !== mregs[i] || rdat2 !== mregs[i + 1]) begin
        errs++; $display("FAIL rnd_final%0d got=%h/%h exp=%h/%h", i, rdat1, rdat2, mregs[i], mregs[i + 1]); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_writes();
    test_cmp();
    test_store_wrap();
    test_store_stall();
    test_back_to_back();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
